seg7_pattern_reader: RTL

- Inverse of the hex-to-7-segment decode path: samples an external 7-segment drive bus and recovers the 4-bit hex digit it shows.
- Filters glitches and multiplexing transients by requiring the pattern to be stable for STABLE_CYCLES cycles.
- Delivers each new stable digit once, over a one-entry valid/ready output buffer.
- Used on scoreboards and loopback paths that read back HEX display drive.

---
 rtl/seg7_pkg.sv | 22 ++
 rtl/seg7_pattern_reader_if.sv | 29 ++
 rtl/seg7_glyph_lookup.sv | 24 ++
 rtl/seg7_pattern_reader.sv | 139 +++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and state types for the 7-segment pattern reader.
// Glyphs are active-low, bit 6 = g down to bit 0 = a.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        F_IDLE  = 1'b0,
        F_COUNT = 1'b1
    } filt_state_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_e;

endpackage

// File: rtl/seg7_pattern_reader_if.sv
// Output side of the reader: one-entry valid/ready digit stream plus status levels.
interface seg7_pattern_reader_if;

    logic [3:0] digit;
    logic       out_valid;
    logic       pattern_err;
    logic       blank;
    logic       overflow;
    logic       out_ready;

    modport master (
        output digit,
        output out_valid,
        output pattern_err,
        output blank,
        output overflow,
        input  out_ready
    );

    modport slave (
        input  digit,
        input  out_valid,
        input  pattern_err,
        input  blank,
        input  overflow,
        output out_ready
    );

endinterface

// File: rtl/seg7_glyph_lookup.sv
// Combinational reverse lookup of an active-low segment pattern to its hex value.
// A miss returns value 0 with hit low.
module seg7_glyph_lookup
    import seg7_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] value_o,
    output logic       hit_o
);

    logic [15:0] match_s;

    // Glyphs are pairwise distinct, so at most one match bit is set and OR-ing is safe.
    always_comb begin
        match_s = 16'h0000;
        value_o = 4'd0;
        for (int i = 0; i < 16; i++) begin
            match_s[i] = (pattern_i == SEG_GLYPH[i]);
            value_o    = value_o | ({4{match_s[i]}} & 4'(i));
        end
        hit_o = |match_s;
    end

endmodule

// File: rtl/seg7_pattern_reader.sv
// Recovers the hex digit shown on an asynchronous 7-segment drive bus, filters transients,
// and hands each newly stable digit out once through a one-entry valid/ready buffer.
module seg7_pattern_reader
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic [6:0]            seg_in,
    seg7_pattern_reader_if.master out_if
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [6:0]       sync1_q;
    logic [6:0]       s_q;
    logic [6:0]       cand_q;
    logic [6:0]       last_acc_q;
    logic [CNT_W-1:0] cnt_q;
    filt_state_e      fstate_q;
    buf_state_e       bstate_q;
    logic [3:0]       digit_q;
    logic             valid_q;
    logic             err_q;
    logic             blank_q;
    logic             ovf_q;

    logic [3:0]       lk_val_s;
    logic             lk_hit_s;
    logic             accept_s;
    logic             new_acc_s;
    logic             offer_s;

    seg7_glyph_lookup u_lookup (
        .pattern_i (cand_q),
        .value_o   (lk_val_s),
        .hit_o     (lk_hit_s)
    );

    // A change of s always wins over acceptance, so accept needs s still equal to cand.
    assign accept_s  = (fstate_q == F_COUNT) && (s_q == cand_q) && (cnt_q == CNT_LAST);
    assign new_acc_s = accept_s && (cand_q != last_acc_q);
    assign offer_s   = new_acc_s && (cand_q != SEG_BLANK);

    // Two-flop synchronizer for the asynchronous segment bus.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            sync1_q <= SEG_BLANK;
            s_q     <= SEG_BLANK;
        end else begin
            sync1_q <= seg_in;
            s_q     <= sync1_q;
        end
    end

    // Stability filter: restart on any change, accept once after STABLE_CYCLES equal samples.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            cand_q   <= SEG_BLANK;
            cnt_q    <= '0;
            fstate_q <= F_IDLE;
        end else if (s_q != cand_q) begin
            cand_q   <= s_q;
            cnt_q    <= '0;
            fstate_q <= F_COUNT;
        end else begin
            case (fstate_q)
                F_COUNT: begin
                    if (cnt_q == CNT_LAST) begin
                        fstate_q <= F_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                F_IDLE: begin
                    fstate_q <= F_IDLE;
                end
                default: begin
                    fstate_q <= F_IDLE;
                end
            endcase
        end
    end

    // Accept bookkeeping and the one-entry output buffer.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            last_acc_q <= SEG_BLANK;
            blank_q    <= 1'b1;
            bstate_q   <= EMPTY;
            digit_q    <= 4'd0;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            if (new_acc_s) begin
                last_acc_q <= cand_q;
                blank_q    <= (cand_q == SEG_BLANK);
            end
            case (bstate_q)
                EMPTY: begin
                    if (offer_s) begin
                        digit_q  <= lk_val_s;
                        err_q    <= !lk_hit_s;
                        valid_q  <= 1'b1;
                        bstate_q <= FULL;
                    end
                end
                FULL: begin
                    if (out_if.out_ready) begin
                        if (offer_s) begin
                            digit_q <= lk_val_s;
                            err_q   <= !lk_hit_s;
                        end else begin
                            valid_q  <= 1'b0;
                            bstate_q <= EMPTY;
                        end
                    end else if (offer_s) begin
                        // Held entry is kept; the newcomer is lost and flagged.
                        ovf_q <= 1'b1;
                    end
                end
                default: begin
                    bstate_q <= EMPTY;
                    valid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_if.digit       = digit_q;
    assign out_if.out_valid   = valid_q;
    assign out_if.pattern_err = err_q;
    assign out_if.blank       = blank_q;
    assign out_if.overflow    = ovf_q;

endmodule
